mem_dispatch_ctrl: RTL
======================

Name: mem_dispatch_ctrl

Overview:
- Transmitting end of the d-cache control interface that the memory-stage glue consumes.
- Each dispatch selects one memory operation: either the committed store at the store-queue head, or the oldest eligible load in the load queue.
- Resolves store-to-load bypass and drives the d-cache control bundle (valid, mem_action, dispatch_index, bypass_possible, bypass_index, NOP).
- Holds the bundle stable until the memory stage reports done, then pulses a dequeue/issued indication back to the queues.

Parameters:
LQ_DEPTH, 8, load queue entries (power of 2)
SQ_DEPTH, 8, store queue entries (power of 2)
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_lq_ready  in  LQ_DEPTH  load entry valid, address computed, not yet dispatched
i_lq_addr  in  LQ_DEPTH*ADDR_WIDTH  load addresses
i_lq_head  in  log2(LQ_DEPTH)  oldest load index
i_lq_older_sq  in  LQ_DEPTH*SQ_DEPTH  bit [l*SQ_DEPTH+s]=1: store s is older than load l
i_sq_valid  in  SQ_DEPTH  store entry occupied
i_sq_addr_ready  in  SQ_DEPTH  store address known
i_sq_data_ready  in  SQ_DEPTH  store data known
i_sq_addr  in  SQ_DEPTH*ADDR_WIDTH  store addresses
i_sq_head  in  log2(SQ_DEPTH)  oldest store index
i_sq_tail  in  log2(SQ_DEPTH)  next free store index
i_sq_head_commit_ok  in  1  head store is oldest in active list, may write
i_flush  in  1  branch-recovery squash of speculative loads
i_done  in  1  memory stage done for current dispatch
o_valid  out  1  dispatch bundle valid
o_mem_action  out  1  0=READ, 1=WRITE
o_dispatch_index  out  log2(max(LQ_DEPTH,SQ_DEPTH))  LQ or SQ index being dispatched
o_bypass_possible  out  1  load satisfied from store queue
o_bypass_index  out  log2(SQ_DEPTH)  forwarding store index
o_nop  out  1  in-flight load squashed; suppress write-back
o_lq_dispatched  out  1  one-cycle pulse: load at o_dispatch_index finished
o_sq_dispatched  out  1  one-cycle pulse: head store finished, dequeue

Behaviour:
- Reset: FSM=IDLE; every output 0.
- States:
  - IDLE: evaluate candidates. If a candidate exists, register the bundle, set o_valid=1, go to BUSY; the bundle appears the cycle after the candidate is visible.
  - BUSY: bundle held constant except o_nop. On i_done=1, pulse o_lq_dispatched or o_sq_dispatched (per o_mem_action), drop o_valid the next cycle, and return to IDLE. Minimum spacing between dispatch starts is 2 cycles.
- Priority: a store wins over any load when i_sq_valid[head] & addr_ready & data_ready & i_sq_head_commit_ok.
- Store bundle: o_mem_action=1, o_dispatch_index=i_sq_head, bypass=0, nop=0.
- Load eligibility (load l):
  - i_lq_ready[l]=1.
  - Every older valid store has addr_ready=1.
  - If any older store matches the load on addr[ADDR_WIDTH-1:2], the youngest such store (nearest i_sq_tail, scanning backward with wrap-around) must have data_ready=1.
- Load selection: first eligible l scanning from i_lq_head upward modulo LQ_DEPTH.
  - With a matching store: o_bypass_possible=1 and o_bypass_index=youngest matching store.
  - Otherwise bypass=0.
- Flush:
  - In IDLE: suppresses selection that cycle.
  - In BUSY on a load: set o_nop=1 (sticky until exit). Stay in BUSY until i_done, because the cache transaction must complete. Pulse o_lq_dispatched anyway.
  - In BUSY on a store: ignored, since stores are committed.
- i_flush and i_done in the same cycle: o_nop is set, the pulse still fires, and the FSM returns to IDLE.
- An entry stays ready in the queue until the dispatched pulse, so the FSM never reselects it while in BUSY.
- Empty queues: remain in IDLE with outputs 0.
- Full-queue wrap: head/tail scanning uses modulo arithmetic; i_sq_head==i_sq_tail with valid[head]=1 means full.
- Reset mid-BUSY: outputs clear immediately (async); the queues own recovery.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY -> o_valid, o_nop and both pulses drop to 0 without waiting for a clock edge.
- Single load: LQ entry 2 ready, addr 0x100, no stores -> next cycle o_valid=1, action=0, index=2, bypass=0. i_done held 3 cycles later -> o_lq_dispatched pulse, o_valid=0 the following cycle.
- Bypass:
  - Setup: stores 1 and 3 older, both addr 0x104, data ready; sq_tail=4; load 0 addr 0x106.
  - Required: o_bypass_possible=1, o_bypass_index=3.
  - Done-path timing: i_done=1 the same cycle as o_valid -> BUSY lasts 1 cycle.
- Block on unknown address: an older store has addr_ready=0 -> no load dispatched. Set addr_ready=1 -> dispatch begins next cycle.
- Store priority: load 0 eligible and SQ head 5 ready with commit_ok=1 -> action=1, index=5 first; the load dispatches after the store's o_sq_dispatched.
- Flush: i_flush pulsed during a load in BUSY, i_done 2 cycles later -> o_nop=1 from the cycle after flush through the done cycle, and the pulse still fires. Flush during a store -> o_nop stays 0.

Source files
------------

// File: rtl/mem_dispatch_ctrl.sv
// Memory-stage dispatch controller: picks either the committed store at the
// store-queue head or the oldest eligible load, resolves store-to-load
// forwarding, and holds the d-cache control bundle until the memory stage
// reports done.
module mem_dispatch_ctrl #(
  parameter int unsigned LQ_DEPTH   = 8,
  parameter int unsigned SQ_DEPTH   = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  localparam int unsigned LQ_W  = $clog2(LQ_DEPTH),
  localparam int unsigned SQ_W  = $clog2(SQ_DEPTH),
  localparam int unsigned IDX_W = $clog2((LQ_DEPTH > SQ_DEPTH) ? LQ_DEPTH : SQ_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [LQ_DEPTH-1:0]            i_lq_ready,
  input  logic [LQ_DEPTH*ADDR_WIDTH-1:0] i_lq_addr,
  input  logic [LQ_W-1:0]                i_lq_head,
  input  logic [LQ_DEPTH*SQ_DEPTH-1:0]   i_lq_older_sq,
  input  logic [SQ_DEPTH-1:0]            i_sq_valid,
  input  logic [SQ_DEPTH-1:0]            i_sq_addr_ready,
  input  logic [SQ_DEPTH-1:0]            i_sq_data_ready,
  input  logic [SQ_DEPTH*ADDR_WIDTH-1:0] i_sq_addr,
  input  logic [SQ_W-1:0]                i_sq_head,
  input  logic [SQ_W-1:0]                i_sq_tail,
  input  logic                           i_sq_head_commit_ok,
  input  logic                           i_flush,
  input  logic                           i_done,
  output logic                           o_valid,
  output logic                           o_mem_action,
  output logic [IDX_W-1:0]               o_dispatch_index,
  output logic                           o_bypass_possible,
  output logic [SQ_W-1:0]                o_bypass_index,
  output logic                           o_nop,
  output logic                           o_lq_dispatched,
  output logic                           o_sq_dispatched
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic [LQ_DEPTH-1:0]   ld_elig;
  logic [LQ_DEPTH-1:0]   ld_byp;
  logic [SQ_W-1:0]       ld_byp_idx [LQ_DEPTH];
  logic                  all_known;
  logic                  fwd_found;
  logic                  fwd_data;
  logic [SQ_W-1:0]       s_idx;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [ADDR_WIDTH-1:0] s_addr;

  logic                  sel_found;
  logic [LQ_W-1:0]       sel_idx;
  logic [LQ_W-1:0]       l_idx;
  logic                  st_cand;

  // Per-load eligibility and youngest-older-matching-store search (backward from tail).
  always_comb begin
    ld_elig   = '0;
    ld_byp    = '0;
    all_known = 1'b0;
    fwd_found = 1'b0;
    fwd_data  = 1'b0;
    s_idx     = '0;
    l_addr    = '0;
    s_addr    = '0;
    for (int unsigned l = 0; l < LQ_DEPTH; l++) ld_byp_idx[l] = '0;
    for (int unsigned l = 0; l < LQ_DEPTH; l++) begin
      all_known = 1'b1;
      fwd_found = 1'b0;
      fwd_data  = 1'b0;
      l_addr    = i_lq_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
      for (int unsigned s = 0; s < SQ_DEPTH; s++) begin
        if (i_lq_older_sq[l*SQ_DEPTH + s] && i_sq_valid[s] && !i_sq_addr_ready[s])
          all_known = 1'b0;
      end
      // d = SQ_DEPTH lands on the tail slot itself, which is occupied only when full.
      for (int unsigned d = 1; d <= SQ_DEPTH; d++) begin
        s_idx  = i_sq_tail - SQ_W'(d);
        s_addr = i_sq_addr[s_idx*ADDR_WIDTH +: ADDR_WIDTH];
        if (!fwd_found && i_lq_older_sq[l*SQ_DEPTH + s_idx] && i_sq_valid[s_idx] &&
            i_sq_addr_ready[s_idx] && ((l_addr >> 2) == (s_addr >> 2))) begin
          fwd_found     = 1'b1;
          ld_byp_idx[l] = s_idx;
          fwd_data      = i_sq_data_ready[s_idx];
        end
      end
      ld_byp[l]  = fwd_found;
      ld_elig[l] = i_lq_ready[l] && all_known && (!fwd_found || fwd_data);
    end
  end

  // Candidate selection; the entry whose dispatched pulse is showing is still
  // marked ready in its queue that cycle, so it is masked out here.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    l_idx     = '0;
    for (int unsigned k = 0; k < LQ_DEPTH; k++) begin
      l_idx = i_lq_head + LQ_W'(k);
      if (!sel_found && ld_elig[l_idx] &&
          !(o_lq_dispatched && (l_idx == LQ_W'(o_dispatch_index)))) begin
        sel_found = 1'b1;
        sel_idx   = l_idx;
      end
    end
    st_cand = i_sq_valid[i_sq_head] && i_sq_addr_ready[i_sq_head] &&
              i_sq_data_ready[i_sq_head] && i_sq_head_commit_ok && !o_sq_dispatched;
  end

  // Dispatch FSM with registered bundle; bundle fields (not o_valid) stay up
  // through the pulse cycle so the queues see which entry finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      o_valid           <= 1'b0;
      o_mem_action      <= 1'b0;
      o_dispatch_index  <= '0;
      o_bypass_possible <= 1'b0;
      o_bypass_index    <= '0;
      o_nop             <= 1'b0;
      o_lq_dispatched   <= 1'b0;
      o_sq_dispatched   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_lq_dispatched <= 1'b0;
          o_sq_dispatched <= 1'b0;
          o_nop           <= 1'b0;
          if (!i_flush && st_cand) begin
            state             <= BUSY;
            o_valid           <= 1'b1;
            o_mem_action      <= 1'b1;
            o_dispatch_index  <= IDX_W'(i_sq_head);
            o_bypass_possible <= 1'b0;
            o_bypass_index    <= '0;
          end else if (!i_flush && sel_found) begin
            state             <= BUSY;
            o_valid           <= 1'b1;
            o_mem_action      <= 1'b0;
            o_dispatch_index  <= IDX_W'(sel_idx);
            o_bypass_possible <= ld_byp[sel_idx];
            o_bypass_index    <= ld_byp[sel_idx] ? ld_byp_idx[sel_idx] : '0;
          end else begin
            o_valid           <= 1'b0;
            o_mem_action      <= 1'b0;
            o_dispatch_index  <= '0;
            o_bypass_possible <= 1'b0;
            o_bypass_index    <= '0;
          end
        end
        BUSY: begin
          // A flush coinciding with done still marks the load as squashed.
          o_nop <= o_nop | (i_flush & ~o_mem_action);
          if (i_done) begin
            state           <= IDLE;
            o_valid         <= 1'b0;
            o_lq_dispatched <= ~o_mem_action;
            o_sq_dispatched <= o_mem_action;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
